// File: rtl/spike_rate_avg_if.sv
// Window-strobe input, count input and moving-average outputs of spike_rate_avg.
interface spike_rate_avg_if #(
   parameter int DEPTH_LOG2 = 3
);
   logic                     slow_clk;
   logic [31:0]              cnt_in;
   logic                     clear;
   logic [31:0]              avg_out;
   logic [32+DEPTH_LOG2-1:0] sum_out;
   logic                     rate_upd;
   logic                     window_full;

   modport master (
      output slow_clk, cnt_in, clear,
      input  avg_out, sum_out, rate_upd, window_full
   );

   modport slave (
      input  slow_clk, cnt_in, clear,
      output avg_out, sum_out, rate_upd, window_full
   );
endinterface

// File: rtl/spike_rate_avg.sv
// Moving average of the last 2^DEPTH_LOG2 per-window spike counts.
// The window strobe is resynchronised from slow_clk and edge-detected in the fast_clk domain.
module spike_rate_avg #(
   parameter int DEPTH_LOG2 = 3
) (
   input  logic             fast_clk,
   input  logic             reset,
   spike_rate_avg_if.slave  bus
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int SUM_W = 32 + DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);

   logic                  sync_p0;
   logic                  sync_p1;
   logic                  sync_p2;
   logic [1:0]            primed;
   logic                  armed;
   logic                  strobe;

   logic [31:0]           hist [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2:0]   fill;
   logic [DEPTH_LOG2:0]   fill_nxt;
   logic [SUM_W-1:0]      sum;
   logic [SUM_W-1:0]      sum_nxt;
   logic [31:0]           avg;
   logic                  rate_upd;
   logic                  window_full;

   function automatic logic [31:0] avg_of(input logic [SUM_W-1:0] s);
      return s[SUM_W-1:DEPTH_LOG2];
   endfunction

   // Synchroniser stage. After reset the flops hold fake zeros, so strobes stay
   // disarmed until a genuine low level of slow_clk has come through the chain;
   // this keeps a slow_clk already high at reset release from firing.
   always_ff @(posedge fast_clk or posedge reset) begin
      if (reset) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         sync_p2 <= 1'b0;
         primed  <= 2'b00;
         armed   <= 1'b0;
      end else begin
         sync_p0 <= bus.slow_clk;
         sync_p1 <= sync_p0;
         sync_p2 <= sync_p1;
         primed  <= {primed[0], 1'b1};
         armed   <= armed | (primed[1] & ~sync_p1);
      end
   end

   assign strobe = sync_p1 & ~sync_p2 & armed;

   always_comb begin
      sum_nxt  = sum + SUM_W'(bus.cnt_in) - SUM_W'(hist[wr_ptr]);
      fill_nxt = (fill == FULL) ? fill : fill + 1'b1;
   end

   // Accumulate stage: the evicted slot is subtracted as the new count is added.
   // Empty slots hold zero, so the fixed shift is the divisor even before the
   // history is full.
   always_ff @(posedge fast_clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
         wr_ptr      <= '0;
         fill        <= '0;
         sum         <= '0;
         avg         <= '0;
         rate_upd    <= 1'b0;
         window_full <= 1'b0;
      end else begin
         rate_upd <= 1'b0;
         if (bus.clear) begin
            for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
            wr_ptr      <= '0;
            fill        <= '0;
            sum         <= '0;
            avg         <= '0;
            window_full <= 1'b0;
         end else if (strobe) begin
            hist[wr_ptr] <= bus.cnt_in;
            wr_ptr       <= wr_ptr + 1'b1;
            fill         <= fill_nxt;
            sum          <= sum_nxt;
            avg          <= avg_of(sum_nxt);
            rate_upd     <= 1'b1;
            window_full  <= (fill_nxt == FULL);
         end
      end
   end

   assign bus.avg_out     = avg;
   assign bus.sum_out     = sum;
   assign bus.rate_upd    = rate_upd;
   assign bus.window_full = window_full;
endmodule

// File: tb/tb_spike_rate_avg.sv
// Bench for spike_rate_avg: queue-based moving-average model checked every cycle,
// directed windows with literal expectations, then randomized windows and clears.
module tb_spike_rate_avg;
   localparam int DL    = 3;
   localparam int DEPTH = 1 << DL;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   spike_rate_avg_if #(.DEPTH_LOG2(DL)) bus ();
   spike_rate_avg #(.DEPTH_LOG2(DL)) dut (.fast_clk(clk), .reset(reset), .bus(bus));

   typedef struct {
      int          due;
      logic [31:0] v;
      bit          clr;
   } ev_t;

   ev_t             sched[$];
   longint unsigned mq[$];
   int              mfill  = 0;
   int              cyc    = 0;
   int              checks = 0;
   int              errors = 0;
   int              npulse;
   int              pcyc;
   int              rcyc;
   int              ramp[8] = '{1, 2, 3, 5, 6, 7, 8, 10};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: history is the last DEPTH accepted counts, the average is
   // their sum divided by DEPTH. An event due at cycle d is the posedge numbered d.
   task automatic model_step();
      bit              exp_upd = 0;
      bit              has_clr = 0;
      longint unsigned s = 0;
      if (reset) begin
         sched.delete();
         mq.delete();
         mfill = 0;
      end else begin
         foreach (sched[i]) if (sched[i].due == cyc && sched[i].clr) has_clr = 1;
         if (has_clr) begin
            mq.delete();
            mfill = 0;
         end else begin
            foreach (sched[i]) begin
               if (sched[i].due == cyc && !sched[i].clr) begin
                  mq.push_back(longint'(sched[i].v));
                  if (mq.size() > DEPTH) void'(mq.pop_front());
                  mfill++;
                  exp_upd = 1;
               end
            end
         end
         for (int i = sched.size() - 1; i >= 0; i--) if (sched[i].due <= cyc) sched.delete(i);
      end
      foreach (mq[i]) s += mq[i];
      chk("cyc_upd",  64'(bus.rate_upd), 64'(exp_upd));
      chk("cyc_sum",  64'(bus.sum_out), s);
      chk("cyc_avg",  64'(bus.avg_out), s / DEPTH);
      chk("cyc_full", 64'(bus.window_full), 64'(mfill >= DEPTH));
   endtask

   initial begin
      forever begin
         @(negedge clk);
         model_step();
      end
   end

   // One window: slow_clk high for hi cycles, low for lo cycles; optional clear
   // asserted clr_off cycles after the rising edge (-1 = none).
   task automatic window(input logic [31:0] v, input int hi, input int lo, input int clr_off);
      @(negedge clk); #1;
      bus.cnt_in   = v;
      bus.slow_clk = 1'b1;
      rcyc   = cyc;
      npulse = 0;
      pcyc   = -1;
      sched.push_back('{cyc + 3, v, 1'b0});
      if (clr_off == 0) begin
         bus.clear = 1'b1;
         sched.push_back('{cyc + 1, 32'd0, 1'b1});
      end
      for (int k = 1; k <= hi + lo; k++) begin
         @(negedge clk); #1;
         if (bus.rate_upd) begin
            npulse++;
            pcyc = cyc - rcyc;
         end
         bus.clear = 1'b0;
         if (k == hi) bus.slow_clk = 1'b0;
         if (k == clr_off) begin
            bus.clear = 1'b1;
            sched.push_back('{cyc + 1, 32'd0, 1'b1});
         end
      end
      if (bus.clear) begin
         @(negedge clk); #1;
         bus.clear = 1'b0;
      end
   endtask

   task automatic do_clear();
      @(negedge clk); #1;
      bus.clear = 1'b1;
      sched.push_back('{cyc + 1, 32'd0, 1'b1});
      @(negedge clk); #1;
      bus.clear = 1'b0;
   endtask

   initial begin
      reset        = 1'b1;
      bus.slow_clk = 1'b0;
      bus.cnt_in   = '0;
      bus.clear    = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_sum",  64'(bus.sum_out), 64'd0);
      chk("rst_avg",  64'(bus.avg_out), 64'd0);
      chk("rst_upd",  64'(bus.rate_upd), 64'd0);
      chk("rst_full", 64'(bus.window_full), 64'd0);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      // Eight windows of 10: truncated 10*k/8, full with the eighth.
      for (int k = 1; k <= 8; k++) begin
         window(32'd10, 2, 4, -1);
         chk("ramp_avg",   64'(bus.avg_out), 64'(ramp[k-1]));
         chk("ramp_pulse", 64'(npulse), 64'd1);
         chk("ramp_full",  64'(bus.window_full), 64'(k == 8));
      end
      chk("ramp_sum", 64'(bus.sum_out), 64'd80);

      // Pointer wrap: 18 replaces a 10, then 2 replaces a 10.
      window(32'd18, 2, 4, -1);
      chk("wrap_sum18", 64'(bus.sum_out), 64'd88);
      chk("wrap_avg18", 64'(bus.avg_out), 64'd11);
      window(32'd2, 2, 4, -1);
      chk("wrap_sum2",  64'(bus.sum_out), 64'd80);
      chk("wrap_avg2",  64'(bus.avg_out), 64'd10);

      do_clear();
      chk("clr_sum",  64'(bus.sum_out), 64'd0);
      chk("clr_full", 64'(bus.window_full), 64'd0);

      // Maximum counts: full-width sum must not wrap.
      for (int k = 0; k < 8; k++) window(32'hFFFF_FFFF, 2, 4, -1);
      chk("max_sum",  64'(bus.sum_out), 64'h7_FFFF_FFF8);
      chk("max_avg",  64'(bus.avg_out), 64'hFFFF_FFFF);
      chk("max_full", 64'(bus.window_full), 64'd1);

      // Clear on the strobe cycle wins and discards the sample.
      window(32'd5, 2, 4, 2);
      chk("clrstb_pulse", 64'(npulse), 64'd0);
      chk("clrstb_sum",   64'(bus.sum_out), 64'd0);
      chk("clrstb_full",  64'(bus.window_full), 64'd0);
      window(32'd8, 2, 4, -1);
      chk("clrstb_avg8",  64'(bus.avg_out), 64'd1);

      // Long high level: one pulse, three edges after the first high sample.
      window(32'd40, 20, 4, -1);
      chk("long_pulse", 64'(npulse), 64'd1);
      chk("long_lat",   64'(pcyc), 64'd3);
      chk("long_sum",   64'(bus.sum_out), 64'd48);

      // Clear while the edge is still in the synchroniser: strobe survives.
      window(32'd16, 2, 4, 1);
      chk("inflight_pulse", 64'(npulse), 64'd1);
      chk("inflight_sum",   64'(bus.sum_out), 64'd16);

      // Reset mid-update with slow_clk high, then release while still high.
      for (int k = 0; k < 5; k++) window(32'd20, 2, 4, -1);
      @(negedge clk); #1;
      bus.cnt_in   = 32'd77;
      bus.slow_clk = 1'b1;
      sched.push_back('{cyc + 3, 32'd77, 1'b0});
      repeat (2) @(negedge clk);
      #1;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("midrst_sum",  64'(bus.sum_out), 64'd0);
      chk("midrst_avg",  64'(bus.avg_out), 64'd0);
      chk("midrst_full", 64'(bus.window_full), 64'd0);
      reset  = 1'b0;
      npulse = 0;
      repeat (6) begin
         @(negedge clk); #1;
         if (bus.rate_upd) npulse++;
      end
      chk("midrst_nopulse", 64'(npulse), 64'd0);
      chk("midrst_sum2",    64'(bus.sum_out), 64'd0);
      bus.slow_clk = 1'b0;
      repeat (4) @(negedge clk);
      window(32'd24, 2, 4, -1);
      chk("midrst_pulse", 64'(npulse), 64'd1);
      chk("midrst_avg24", 64'(bus.avg_out), 64'd3);

      // Randomized windows with occasional clears at random offsets.
      for (int n = 0; n < 200; n++) begin
         automatic logic [31:0] v  = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 1000));
         automatic int          hi = $urandom_range(1, 6);
         automatic int          lo = $urandom_range(3, 6);
         automatic int          co = ($urandom_range(0, 9) == 0) ? $urandom_range(0, hi + lo - 1) : -1;
         window(v, hi, lo, co);
      end

      repeat (4) @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/spike_rate_avg.md
SPIKE_RATE_AVG -- requirements
Module: spike_rate_avg

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 3, meaning log2 of the number of averaged count windows (legal range 1..4, so DEPTH = 2^DEPTH_LOG2 is 2..16).
REQ-002 SHALL have port fast_clk, input, width 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, width 1, asynchronous active-high reset.
REQ-004 SHALL have port slow_clk, input, width 1, window strobe from the spike counter, treated as asynchronous data and never used as a clock.
REQ-005 SHALL have port cnt_in, input, width 32, per-window spike count from the upstream counter, stable while slow_clk is high.
REQ-006 SHALL have port clear, input, width 1, synchronous flush of the averaging history.
REQ-007 SHALL have port avg_out, output, width 32, moving-average spike count per window.
REQ-008 SHALL have port sum_out, output, width 32+DEPTH_LOG2, running sum over the window history.
REQ-009 SHALL have port rate_upd, output, width 1, one-cycle pulse marking a new avg_out.
REQ-010 SHALL have port window_full, output, width 1, high once DEPTH samples have been accumulated since reset or clear.

Function
REQ-011 SHALL pass slow_clk through a 2-flop synchroniser plus one history flop; strobe = sync2 & ~hist.
REQ-012 SHALL generate exactly one strobe per slow_clk rising edge, with none on falling edges and none while slow_clk is held high.
REQ-013 SHALL keep DEPTH x 32-bit history registers, a write pointer wr_ptr (DEPTH_LOG2 bits) and a fill counter (DEPTH_LOG2+1 bits).
REQ-014 SHALL, on a strobe cycle without clear: hist[wr_ptr] <= cnt_in; sum <= sum + cnt_in - hist[wr_ptr]; wr_ptr <= wr_ptr+1 (wraps DEPTH-1 -> 0); fill <= fill+1, saturating at DEPTH.
REQ-015 SHALL compute sum at full width 32+DEPTH_LOG2 with no overflow possible, since at most DEPTH 32-bit terms are summed.
REQ-016 SHALL set avg_out to the new sum >> DEPTH_LOG2 (truncating), registered in the same edge as sum, so avg_out always equals sum_out >> DEPTH_LOG2.
REQ-017 SHALL divide by DEPTH before the window is full, with empty slots counting as zero, and SHALL NOT use a fill-based divisor.
REQ-018 SHALL drive rate_upd high for exactly the one cycle following each accepted strobe, coincident with the updated avg_out.
REQ-019 SHALL make latency from the first fast_clk edge sampling slow_clk high to rate_upd high equal to 3 fast_clk edges.
REQ-020 SHALL drive window_full = (fill == DEPTH), asserted in the same cycle as the DEPTH-th rate_upd and held until reset or clear.
REQ-021 SHALL, when clear is high, zero all hist entries, sum, avg_out, wr_ptr, fill and window_full on that edge, and SHALL NOT pulse rate_upd.
REQ-022 SHALL give clear priority over a simultaneous strobe: that sample is discarded and no rate_upd is produced.
REQ-023 SHALL leave the synchroniser flops unaffected by clear, so an edge in flight still produces its strobe after clear deasserts.
REQ-024 SHALL hold avg_out and sum_out constant between updates.

Reset
REQ-025 SHALL, while reset is high, asynchronously force sync flops, hist, sum_out, avg_out, wr_ptr, fill, rate_upd and window_full to 0.
REQ-026 SHALL produce no spurious strobe on reset release when slow_clk is already high; the first strobe occurs on the next slow_clk rising edge.
REQ-027 SHALL, on reset asserted mid-update, discard the pending sample and resume from the all-zero state after release.

Verification
REQ-028 SHALL cover: DEPTH_LOG2=3, eight windows with cnt_in=10 -> avg_out 1,2,...,10 (truncated 10*k/8); window_full rises with the 8th rate_upd; sum_out=80.
REQ-029 SHALL cover: full window of 10s, then ninth window cnt_in=18 -> sum_out=88, avg_out=11; tenth window cnt_in=2 -> sum_out=80, avg_out=10 (wr_ptr wrap).
REQ-030 SHALL cover: cnt_in=32'hFFFF_FFFF for 8 windows -> sum_out=35'h7_FFFF_FFF8, avg_out=32'hFFFF_FFFF, no wrap.
REQ-031 SHALL cover: clear on the strobe cycle -> no rate_upd, sum_out=0, window_full=0; the next window of cnt_in=8 -> avg_out=1.
REQ-032 SHALL cover: slow_clk high for 20 fast_clk cycles -> exactly one rate_upd, 3 edges after the first high sample.
REQ-033 SHALL cover: reset asserted after 5 windows while slow_clk is high, then released -> all outputs 0, no rate_upd until the next slow_clk rising edge.
